button_array: RTL and testbench

- Parametrised N-channel successor to the single-button trigger block. Each channel synchronises, debounces and classifies one raw push-button input.
- Per channel it emits one-cycle pulses for a short press, a long press and optional auto-repeat, with per-channel lock suppression.
- Sits between the board button pins and the UI/command FSMs, which consume the pulses directly on clk.

---
 rtl/button_array_pkg.sv | 24 ++
 rtl/button_deb.sv | 64 ++++++
 rtl/button_array.sv | 115 +++++++++++
 tb/tb_button_array.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_array_pkg.sv
// rtl/button_array_pkg.sv - shared FSM states and sizing helpers for button_array
package button_array_pkg;

  localparam int CLK_KHZ = 50_000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRESS  = 2'd1,
    ST_LONG   = 2'd2,
    ST_LOCKED = 2'd3
  } btn_state_e;

  function automatic int c_ms(input int ms);
    return ms * CLK_KHZ;
  endfunction

  // Width that can hold every value 0..max(a,b)-1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/button_deb.sv
// rtl/button_deb.sv - two-flop synchroniser and hold-time debouncer for one button
module button_deb
  import button_array_pkg::*;
#(
  parameter int DEB_CMAX = c_ms(5)
) (
  input  logic clk,
  input  logic rst,
  input  logic a_sig,
  output logic sig,
  output logic pe_sig,
  output logic ne_sig
);

  localparam int CW = cnt_width(DEB_CMAX, 2);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          pe_q, pe_d;
  logic          ne_q, ne_d;
  logic          s;

  assign s = sync_q[1];

  // stable only follows s after it has disagreed for DEB_CMAX consecutive cycles
  always_comb begin
    sync_d   = {sync_q[0], a_sig};
    cnt_d    = '0;
    stable_d = stable_q;
    pe_d     = 1'b0;
    ne_d     = 1'b0;
    if (s != stable_q) begin
      if (cnt_q == CW'(DEB_CMAX - 1)) begin
        stable_d = s;
        pe_d     = s;
        ne_d     = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      pe_q     <= 1'b0;
      ne_q     <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      pe_q     <= pe_d;
      ne_q     <= ne_d;
    end
  end

  assign sig    = stable_q;
  assign pe_sig = pe_q;
  assign ne_sig = ne_q;

endmodule

// File: rtl/button_array.sv
// rtl/button_array.sv - N-channel button debounce and short/long/repeat press classifier
module button_array
  import button_array_pkg::*;
#(
  parameter int N         = 4,
  parameter int DEB_CMAX  = c_ms(5),
  parameter int LONG_CMAX = c_ms(800),
  parameter int REP_CMAX  = c_ms(150)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a_btn,
  input  logic [N-1:0] lock,
  input  logic [N-1:0] rep_en,
  output logic [N-1:0] held,
  output logic [N-1:0] tr_short,
  output logic [N-1:0] tr_long,
  output logic [N-1:0] tr_rep
);

  localparam int DCW = cnt_width(LONG_CMAX, REP_CMAX);

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic           sig, pe, ne;
    btn_state_e     state_q, state_d;
    logic [DCW-1:0] dc_q, dc_d;
    logic           held_q, held_d;
    logic           short_q, short_d;
    logic           long_q, long_d;
    logic           rep_q, rep_d;

    button_deb #(.DEB_CMAX(DEB_CMAX)) u_deb (
      .clk    (clk),
      .rst    (rst),
      .a_sig  (a_btn[i]),
      .sig    (sig),
      .pe_sig (pe),
      .ne_sig (ne)
    );

    // lock is latched into LOCKED at press time; later it only masks pulses
    always_comb begin
      state_d = state_q;
      dc_d    = dc_q;
      held_d  = sig;
      short_d = 1'b0;
      long_d  = 1'b0;
      rep_d   = 1'b0;
      case (state_q)
        ST_IDLE: begin
          dc_d = '0;
          if (pe) state_d = lock[i] ? ST_LOCKED : ST_PRESS;
        end
        ST_PRESS: begin
          if (ne) begin
            short_d = ~lock[i];
            dc_d    = '0;
            state_d = ST_IDLE;
          end else if (dc_q == DCW'(LONG_CMAX - 1)) begin
            long_d  = ~lock[i];
            dc_d    = '0;
            state_d = ST_LONG;
          end else begin
            dc_d = dc_q + 1'b1;
          end
        end
        ST_LONG: begin
          if (ne) begin
            dc_d    = '0;
            state_d = ST_IDLE;
          end else if (!rep_en[i]) begin
            dc_d = '0;
          end else if (dc_q == DCW'(REP_CMAX - 1)) begin
            rep_d = ~lock[i];
            dc_d  = '0;
          end else begin
            dc_d = dc_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          dc_d = '0;
          if (ne) state_d = ST_IDLE;
        end
        default: begin
          dc_d    = '0;
          state_d = ST_IDLE;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_IDLE;
        dc_q    <= '0;
        held_q  <= 1'b0;
        short_q <= 1'b0;
        long_q  <= 1'b0;
        rep_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        dc_q    <= dc_d;
        held_q  <= held_d;
        short_q <= short_d;
        long_q  <= long_d;
        rep_q   <= rep_d;
      end
    end

    assign held[i]     = held_q;
    assign tr_short[i] = short_q;
    assign tr_long[i]  = long_q;
    assign tr_rep[i]   = rep_q;
  end

endmodule

// File: tb/tb_button_array.sv
// tb/tb_button_array.sv - scoreboard bench for button_array with directed press scenarios
module tb_button_array;

  localparam int N = 2;
  localparam int K_RISE = 0, K_FALL = 1, K_SHORT = 2, K_LONG = 3, K_REP = 4;

  typedef struct {
    int kind;
    int ch;
    int cyc;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] a_btn, lock, rep_en;
  logic [N-1:0] held, tr_short, tr_long, tr_rep;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;
  ev_t  exp_q[$];
  logic [N-1:0] prev_held = '0;

  button_array #(.N(N), .DEB_CMAX(4), .LONG_CMAX(20), .REP_CMAX(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_btn    (a_btn),
    .lock     (lock),
    .rep_en   (rep_en),
    .held     (held),
    .tr_short (tr_short),
    .tr_long  (tr_long),
    .tr_rep   (tr_rep)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_RISE:  return "held_rise";
      K_FALL:  return "held_fall";
      K_SHORT: return "tr_short";
      K_LONG:  return "tr_long";
      default: return "tr_rep";
    endcase
  endfunction

  task automatic push(input int kind, input int ch, input int c);
    ev_t e;
    e.kind = kind; e.ch = ch; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int ch);
    int idx;
    idx = -1;
    checks++;
    for (int i = 0; i < exp_q.size(); i++)
      if (idx < 0 && exp_q[i].kind == kind && exp_q[i].ch == ch && exp_q[i].cyc == cyc) idx = i;
    if (idx < 0) begin
      errors++;
      $display("FAIL event: got %s ch=%0d at cycle %0d, required no such event", kname(kind), ch, cyc);
    end else begin
      exp_q.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      for (int ch = 0; ch < N; ch++) begin
        if (held[ch] && !prev_held[ch]) observe(K_RISE, ch);
        if (!held[ch] && prev_held[ch]) observe(K_FALL, ch);
        if (tr_short[ch]) observe(K_SHORT, ch);
        if (tr_long[ch])  observe(K_LONG, ch);
        if (tr_rep[ch])   observe(K_REP, ch);
        if (tr_short[ch] || tr_long[ch] || tr_rep[ch]) begin
          checks++;
          if (int'(tr_short[ch]) + int'(tr_long[ch]) + int'(tr_rep[ch]) > 1) begin
            errors++;
            $display("FAIL onehot: ch=%0d cycle %0d got %0d pulses, required at most 1", ch, cyc,
                     int'(tr_short[ch]) + int'(tr_long[ch]) + int'(tr_rep[ch]));
          end
        end
      end
    end
    prev_held = held;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic drain(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events missing, first %s ch=%0d at cycle %0d, required 0 missing",
               name, exp_q.size(), kname(exp_q[0].kind), exp_q[0].ch, exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  task automatic check_val(input string name, input logic [N-1:0] got, input logic [N-1:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, got, req);
    end
  endtask

  int t0, t2, tr;

  initial begin
    rst = 1'b1; a_btn = '0; lock = '0; rep_en = '0;
    repeat (3) step();
    check_val("reset_held", held, '0);
    check_val("reset_short", tr_short, '0);
    check_val("reset_long", tr_long, '0);
    check_val("reset_rep", tr_rep, '0);
    rst = 1'b0;
    step();
    mon_on = 1'b1;

    // short press on ch0
    t0 = cyc;
    a_btn[0] = 1'b1;
    push(K_RISE, 0, t0 + 7);
    push(K_FALL, 0, t0 + 17);
    push(K_SHORT, 0, t0 + 17);
    wait_until(t0 + 10);
    a_btn[0] = 1'b0;
    wait_until(t0 + 30);
    drain("short_press");

    // bounce on ch1: 3-cycle phases never qualify
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      a_btn[1] = (i % 2 == 0);
      repeat (3) step();
    end
    a_btn[1] = 1'b0;
    wait_until(t0 + 30);
    check_val("bounce_held", held, '0);
    drain("bounce");

    // long press with auto-repeat; release lands on a repeat tick
    t0 = cyc;
    rep_en[0] = 1'b1;
    a_btn[0] = 1'b1;
    push(K_RISE, 0, t0 + 7);
    push(K_LONG, 0, t0 + 27);
    for (int k = 1; k <= 4; k++) push(K_REP, 0, t0 + 27 + 8 * k);
    push(K_FALL, 0, t0 + 67);
    wait_until(t0 + 60);
    a_btn[0] = 1'b0;
    wait_until(t0 + 80);
    rep_en[0] = 1'b0;
    drain("long_repeat");

    // lock latched at press, released mid-press
    t0 = cyc;
    lock[0] = 1'b1;
    a_btn[0] = 1'b1;
    push(K_RISE, 0, t0 + 7);
    push(K_FALL, 0, t0 + 47);
    wait_until(t0 + 9);
    lock[0] = 1'b0;
    wait_until(t0 + 40);
    a_btn[0] = 1'b0;
    wait_until(t0 + 60);
    drain("locked_press");
    t2 = cyc;
    a_btn[0] = 1'b1;
    push(K_RISE, 0, t2 + 7);
    push(K_FALL, 0, t2 + 17);
    push(K_SHORT, 0, t2 + 17);
    wait_until(t2 + 10);
    a_btn[0] = 1'b0;
    wait_until(t2 + 30);
    drain("after_lock");

    // release coincides with long threshold on ch0; ch1 short press alongside
    t0 = cyc;
    a_btn = 2'b11;
    push(K_RISE, 0, t0 + 7);
    push(K_RISE, 1, t0 + 7);
    push(K_FALL, 1, t0 + 17);
    push(K_SHORT, 1, t0 + 17);
    push(K_FALL, 0, t0 + 27);
    push(K_SHORT, 0, t0 + 27);
    wait_until(t0 + 10);
    a_btn[1] = 1'b0;
    wait_until(t0 + 20);
    a_btn[0] = 1'b0;
    wait_until(t0 + 40);
    drain("threshold_race");

    // reset while in LONG with the button still down
    t0 = cyc;
    a_btn[0] = 1'b1;
    push(K_RISE, 0, t0 + 7);
    push(K_LONG, 0, t0 + 27);
    wait_until(t0 + 35);
    tr = cyc;
    push(K_FALL, 0, tr + 1);
    push(K_RISE, 0, tr + 8);
    push(K_LONG, 0, tr + 28);
    push(K_FALL, 0, tr + 47);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("rst_held", held, '0);
    check_val("rst_tr", tr_short | tr_long | tr_rep, '0);
    wait_until(tr + 40);
    a_btn[0] = 1'b0;
    wait_until(tr + 60);
    drain("reset_mid_long");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
